i2c_target_regs: RTL

I2C target (responder) exposing a small register file to an I2C controller, answering at a fixed 7-bit address. It lets the FPGA act as a stand-in for a color-sensor-style device on a Pmod header, for closed-loop testing of the controller-side poll and setup logic. Local logic loads register values through a simple write port and sees every bus write as a one-cycle pulse.

---
 rtl/i2c_pkg.sv | 27 ++
 rtl/i2c_target_regs_glitch_filter.sv | 49 ++++
 rtl/i2c_target_regs.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target register block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WR_DATA,
    DATA_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } i2c_state_t;

  // R/W bit that follows the 7-bit address.
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  // Level of SDA during the ninth (acknowledge) clock.
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_target_regs_glitch_filter.sv
// Purpose: 2-flop synchronizer for one I2C pin, optionally followed by a stability filter.
// Latency: 2 clocks, plus FILTER_CYCLES when I2C_TARGET_GLITCH_FILTER_EN is defined.
// Backpressure: none; free-running level path.
// Ports: clock, reset (async, active-high), line_in (raw pin), line_out (clean level).
// Sync and filter flops reset to 1, the idle level of an I2C line.
module i2c_glitch_filter #(
  parameter int FILTER_CYCLES = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic line_in,
  output logic line_out
);

  logic [1:0] sync;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], line_in};
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

  logic [CNT_W-1:0] stable_cnt;
  logic             filt;

  // stable_cnt counts consecutive clocks on which the synchronized level
  // differs from the filtered one; any return to the old level restarts it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      filt       <= 1'b1;
      stable_cnt <= '0;
    end else if (sync[1] == filt) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CNT_W'(FILTER_CYCLES - 1)) begin
      filt       <= sync[1];
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

  assign line_out = filt;
`else
  assign line_out = sync[1];
`endif

endmodule

// File: rtl/i2c_target_regs.sv
// Purpose: I2C target at a fixed 7-bit address exposing NUM_REGS 8-bit registers.
// Latency: pin to detected edge 3 clocks (+FILTER_CYCLES with I2C_TARGET_GLITCH_FILTER_EN); sda_oe 1 clock after SCL fall.
// Backpressure: none; no clock stretching, local writes always accepted (bus write wins a same-index collision).
// Ports: clock/reset; scl_in/sda_in pins; sda_oe open-drain pull-down; loc_wr_* local write port;
//        bus_wr_* one-cycle notification of each I2C register write; busy while addressed.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEVICE_ADDRESS = 7'h44,
  parameter int         NUM_REGS       = 16,
  parameter int         FILTER_CYCLES  = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        scl_in,
  input  logic                        sda_in,
  output logic                        sda_oe,
  input  logic                        loc_wr_en,
  input  logic [$clog2(NUM_REGS)-1:0] loc_wr_addr,
  input  logic [7:0]                  loc_wr_data,
  output logic                        bus_wr_valid,
  output logic [$clog2(NUM_REGS)-1:0] bus_wr_addr,
  output logic [7:0]                  bus_wr_data,
  output logic                        busy
);

  localparam int PW = $clog2(NUM_REGS);

  // ---------------- pin conditioning and bus events ----------------
  logic scl_s, sda_s, scl_q, sda_q;

  i2c_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_scl_filter (
    .clock(clock), .reset(reset), .line_in(scl_in), .line_out(scl_s)
  );
  i2c_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_sda_filter (
    .clock(clock), .reset(reset), .line_in(sda_in), .line_out(sda_s)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_s;
      sda_q <= sda_s;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

  // ---------------- datapath state ----------------
  i2c_state_t       state, state_d;
  logic [2:0]       bit_cnt;
  logic [6:0]       shift_in;
  logic [7:0]       shift_out;
  logic [PW-1:0]    ptr;
  logic             rw;
  logic [7:0]       regs [NUM_REGS];

  logic [7:0]    byte_in;
  logic          last_bit;
  logic          addr_match;
  logic [PW-1:0] ptr_inc;

  // byte_in is the complete byte on the rising edge that samples its last bit.
  assign byte_in    = {shift_in, sda_s};
  assign last_bit   = (bit_cnt == 3'd7);
  assign addr_match = (shift_in == DEVICE_ADDRESS);
  assign ptr_inc    = ptr + 1'b1;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state;
    if (stop_det) begin
      state_d = IDLE;
    end else if (start_det) begin
      state_d = ADDR;
    end else if (scl_rise) begin
      case (state)
        ADDR:     if (last_bit) state_d = addr_match ? ADDR_ACK : IDLE;
        ADDR_ACK: state_d = (rw == I2C_RW_READ) ? RD_DATA : PTR;
        PTR:      if (last_bit) state_d = PTR_ACK;
        PTR_ACK:  state_d = WR_DATA;
        WR_DATA:  if (last_bit) state_d = DATA_ACK;
        DATA_ACK: state_d = WR_DATA;
        RD_DATA:  if (last_bit) state_d = RD_ACK;
        RD_ACK:   state_d = (sda_s == I2C_ACK) ? RD_DATA : WAIT_STOP;
        default:  state_d = state;
      endcase
    end
  end

  // ---------------- FSM: outputs / datapath controls ----------------
  logic sda_oe_d, busy_d, bus_we, rd_first, rd_next;

  always_comb begin
    sda_oe_d = sda_oe;
    busy_d   = busy;
    bus_we   = 1'b0;
    rd_first = 1'b0;
    rd_next  = 1'b0;
    if (stop_det) begin
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (!start_det) begin
      // SDA only ever changes while SCL is low.
      if (scl_fall) begin
        case (state)
          ADDR_ACK, PTR_ACK, DATA_ACK: sda_oe_d = 1'b1;
          RD_DATA:                     sda_oe_d = ~shift_out[7];
          default:                     sda_oe_d = 1'b0;
        endcase
      end
      if (scl_rise) begin
        if (state == ADDR && last_bit)    busy_d   = addr_match;
        if (state == WR_DATA && last_bit) bus_we   = 1'b1;
        if (state == ADDR_ACK && rw == I2C_RW_READ) rd_first = 1'b1;
        if (state == RD_ACK && sda_s == I2C_ACK)    rd_next  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sda_oe       <= 1'b0;
      busy         <= 1'b0;
      bit_cnt      <= '0;
      shift_in     <= '0;
      shift_out    <= '0;
      ptr          <= '0;
      rw           <= I2C_RW_WRITE;
      bus_wr_valid <= 1'b0;
      bus_wr_addr  <= '0;
      bus_wr_data  <= '0;
    end else begin
      sda_oe       <= sda_oe_d;
      busy         <= busy_d;
      bus_wr_valid <= bus_we;

      // bit_cnt wraps to 0 after each byte, so ACK states need no clear.
      if (start_det) begin
        bit_cnt <= '0;
      end else if (scl_rise &&
                   (state == ADDR || state == PTR || state == WR_DATA || state == RD_DATA)) begin
        bit_cnt  <= bit_cnt + 1'b1;
        shift_in <= byte_in[6:0];
      end

      if (scl_rise && state == ADDR && last_bit) rw  <= sda_s;
      if (scl_rise && state == PTR && last_bit)  ptr <= byte_in[PW-1:0];

      if (bus_we) begin
        bus_wr_addr <= ptr;
        bus_wr_data <= byte_in;
        ptr         <= ptr_inc;
      end

      // The read byte is captured here, so later local writes cannot alter it.
      if (rd_first) begin
        shift_out <= regs[ptr];
      end else if (rd_next) begin
        shift_out <= regs[ptr_inc];
        ptr       <= ptr_inc;
      end else if (scl_fall && state == RD_DATA && !stop_det) begin
        shift_out <= {shift_out[6:0], 1'b0};
      end
    end
  end

  // ---------------- register file ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      // Same-index collision: the local write is dropped, the bus write lands.
      if (loc_wr_en && !(bus_we && loc_wr_addr == ptr)) regs[loc_wr_addr] <= loc_wr_data;
      if (bus_we) regs[ptr] <= byte_in;
    end
  end

endmodule
